pdp8_dma_arb: RTL

- Arbitrates the single three-cycle data-break memory port (io_ram_*) between two DMA-capable I/O devices: requester 0 is the RF08 disk, requester 1 is a second break device (DF32/RK8 class).
- Sits between the device controllers inside pdp8_io and the memory sequencer that serves io_ram_read_req/io_ram_write_req.
- Latches the winner's address and data, runs one memory cycle, and returns completion plus read data to that winner only.
- Includes a no-response timeout.

---
 rtl/pdp8_dma_arb.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pdp8_dma_arb.sv
// Data-break arbiter: shares the single three-cycle memory port between two
// DMA requesters (RF08 disk and a second break device), with a no-response timeout.
//
// state  | meaning
// IDLE   | sampling requests, nothing outstanding
// GRANT0 | memory cycle in flight for requester 0
// GRANT1 | memory cycle in flight for requester 1
// DONE   | one-cycle completion window, requests not sampled
module pdp8_dma_arb #(
   parameter int ROUND_ROBIN = 1,
   parameter int TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        r0_read_req,
   input  logic        r0_write_req,
   input  logic [14:0] r0_ma,
   input  logic [11:0] r0_out,
   output logic [11:0] r0_in,
   output logic        r0_done,
   output logic        r0_err,
   input  logic        r1_read_req,
   input  logic        r1_write_req,
   input  logic [14:0] r1_ma,
   input  logic [11:0] r1_out,
   output logic [11:0] r1_in,
   output logic        r1_done,
   output logic        r1_err,
   output logic        ram_read_req,
   output logic        ram_write_req,
   output logic [14:0] ram_ma,
   output logic [11:0] ram_out,
   input  logic [11:0] ram_in,
   input  logic        ram_done,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DONE} state_t;

   localparam bit         RR_EN   = (ROUND_ROBIN != 0);
   localparam bit         TO_EN   = (TIMEOUT != 0);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        rd_q, rd_d, wr_q, wr_d;
   logic [14:0] ma_q, ma_d;
   logic [11:0] out_q, out_d;
   logic [11:0] r0_in_q, r0_in_d, r1_in_q, r1_in_d;
   logic        r0_done_q, r0_done_d, r0_err_q, r0_err_d;
   logic        r1_done_q, r1_done_d, r1_err_q, r1_err_d;
   logic        busy_q, busy_d;
   logic        req0, req1, sel1;

   assign req0 = r0_read_req | r0_write_req;
   assign req1 = r1_read_req | r1_write_req;
   assign sel1 = (state_q == GRANT1);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      ma_d      = ma_q;
      out_d     = out_q;
      r0_in_d   = r0_in_q;
      r1_in_d   = r1_in_q;
      r0_done_d = r0_done_q;
      r0_err_d  = r0_err_q;
      r1_done_d = r1_done_q;
      r1_err_d  = r1_err_q;

      case (state_q)
         IDLE: begin
            if (req0 && (!req1 || !RR_EN || !ptr_q)) begin
               ma_d    = r0_ma;
               out_d   = r0_out;
               wr_d    = r0_write_req;
               rd_d    = ~r0_write_req;
               cnt_d   = 8'd0;
               state_d = GRANT0;
            end else if (req1) begin
               ma_d    = r1_ma;
               out_d   = r1_out;
               wr_d    = r1_write_req;
               rd_d    = ~r1_write_req;
               cnt_d   = 8'd0;
               state_d = GRANT1;
            end
         end
         GRANT0, GRANT1: begin
            if (ram_done) begin
               rd_d  = 1'b0;
               wr_d  = 1'b0;
               ptr_d = ~sel1;
               if (sel1) begin
                  r1_done_d = 1'b1;
                  r1_err_d  = 1'b0;
                  if (rd_q) r1_in_d = ram_in;
               end else begin
                  r0_done_d = 1'b1;
                  r0_err_d  = 1'b0;
                  if (rd_q) r0_in_d = ram_in;
               end
               state_d = DONE;
            end else if (TO_EN && cnt_q == TO_LAST) begin
               // memory never answered: abort and report the failure to the owner
               rd_d  = 1'b0;
               wr_d  = 1'b0;
               ptr_d = ~sel1;
               if (sel1) begin
                  r1_done_d = 1'b1;
                  r1_err_d  = 1'b1;
                  r1_in_d   = 12'd0;
               end else begin
                  r0_done_d = 1'b1;
                  r0_err_d  = 1'b1;
                  r0_in_d   = 12'd0;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            r0_done_d = 1'b0;
            r0_err_d  = 1'b0;
            r1_done_d = 1'b0;
            r1_err_d  = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= 1'b0;
         cnt_q     <= 8'd0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         ma_q      <= 15'd0;
         out_q     <= 12'd0;
         r0_in_q   <= 12'd0;
         r1_in_q   <= 12'd0;
         r0_done_q <= 1'b0;
         r0_err_q  <= 1'b0;
         r1_done_q <= 1'b0;
         r1_err_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         ma_q      <= ma_d;
         out_q     <= out_d;
         r0_in_q   <= r0_in_d;
         r1_in_q   <= r1_in_d;
         r0_done_q <= r0_done_d;
         r0_err_q  <= r0_err_d;
         r1_done_q <= r1_done_d;
         r1_err_q  <= r1_err_d;
         busy_q    <= busy_d;
      end
   end

   assign ram_read_req  = rd_q;
   assign ram_write_req = wr_q;
   assign ram_ma        = ma_q;
   assign ram_out       = out_q;
   assign r0_in         = r0_in_q;
   assign r1_in         = r1_in_q;
   assign r0_done       = r0_done_q;
   assign r0_err        = r0_err_q;
   assign r1_done       = r1_done_q;
   assign r1_err        = r1_err_q;
   assign busy          = busy_q;

endmodule
